// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing the write port of a byte fifo between NUM_REQ burst producers.
// Define FIFO_WR_ARB_PRIO0_EN to give producer 0 strict priority at arbitration time.
module fifo_wr_arb #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned TIMEOUT   = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0]                   req_last,
    input  logic [NUM_REQ*DATA_W-1:0]            req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic                                 fifo_full,
    output logic                                 fifo_wen,
    output logic [DATA_W-1:0]                    fifo_wdata,
    output logic [$clog2(NUM_REQ)-1:0]           grant_id,
    output logic                                 busy,
    output logic                                 abort
);

    localparam int unsigned ID_W   = $clog2(NUM_REQ);
    localparam int unsigned BEAT_W = $clog2(BURST_MAX + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic                pick_found;
    logic [ID_W-1:0]     pick_id;
    logic [ID_W-1:0]     cand;
    logic                release_grant;

    // First valid requester at or after rr_ptr, modulo NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = rr_ptr_q;
        cand       = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = ID_W'((32'(rr_ptr_q) + off) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (req_valid[0]) begin
            pick_found = 1'b1;
            pick_id    = '0;
        end
`endif
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        beat_cnt_d    = beat_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        req_ready     = '0;
        fifo_wen      = 1'b0;
        abort         = 1'b0;
        release_grant = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d    = pick_id;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                // Back-pressure freezes both counters; only producer stalls count towards timeout.
                if (!fifo_full) begin
                    req_ready[grant_q] = 1'b1;
                    if (req_valid[grant_q]) begin
                        fifo_wen   = 1'b1;
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                        idle_cnt_d = '0;
                        if (req_last[grant_q] || beat_cnt_q == BEAT_W'(BURST_MAX - 1)) begin
                            release_grant = 1'b1;
                        end
                    end else if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
                        abort         = 1'b1;
                        release_grant = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
            end
        endcase

        if (release_grant) begin
            state_d    = StIdle;
            beat_cnt_d = '0;
            idle_cnt_d = '0;
`ifdef FIFO_WR_ARB_PRIO0_EN
            if (grant_q != '0) begin
                rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
            end
`else
            rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign busy       = (state_q == StGrant);
    assign grant_id   = grant_q;
    assign fifo_wdata = req_data[grant_q*DATA_W +: DATA_W];

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized bench for fifo_wr_arb: a transaction-level arbitration model plus a fifo
// occupancy model drive producers and predict every output on every cycle.
module tb_fifo_wr_arb;
    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int BURST_MAX = 4;
    localparam int TIMEOUT   = 8;
    localparam int ID_W      = 2;
    localparam int DEPTH     = 16;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid, req_last, req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      fifo_full, fifo_wen, busy, abort;
    logic [DATA_W-1:0]         fifo_wdata;
    logic [ID_W-1:0]           grant_id;

    always #5 clk = ~clk;

    fifo_wr_arb #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .BURST_MAX(BURST_MAX),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_wen  (fifo_wen),
        .fifo_wdata(fifo_wdata),
        .grant_id  (grant_id),
        .busy      (busy),
        .abort     (abort)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: owner of the port (-1 when none) and its burst bookkeeping.
    int owner = -1, rr = 0, beats = 0, stall = 0;
    int fifo_cnt = 0;
    int dut_wen_cnt = 0;
    int vprob = 100, hprob = 0, rprob = 0;
    bit rst_done = 0;

    // Producer side: burst length, beat index, forced stall length, current beat data.
    int          blen [NUM_REQ];
    int          bidx [NUM_REQ];
    int          hold [NUM_REQ];
    logic [7:0]  pdata[NUM_REQ];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hold[i] > 0) begin
                req_valid[i] = 1'b0;
                hold[i]--;
            end else begin
                req_valid[i] = ($urandom_range(99) < vprob);
            end
            req_last[i] = (bidx[i] == blen[i] - 1);
            req_data[i*DATA_W +: DATA_W] = pdata[i];
        end
        fifo_full = (fifo_cnt == DEPTH);
    endtask

    task automatic release_owner();
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (owner != 0) rr = (owner + 1) % NUM_REQ;
`else
        rr = (owner + 1) % NUM_REQ;
`endif
        owner = -1;
        beats = 0;
        stall = 0;
    endtask

    task automatic cycle();
        logic [NUM_REQ-1:0] e_ready;
        logic e_wen, e_abort, was_last, rd;
        @(negedge clk);
        e_ready = '0;
        e_wen   = 1'b0;
        e_abort = 1'b0;
        if (owner >= 0 && !fifo_full) begin
            e_ready[owner] = 1'b1;
            e_wen   = req_valid[owner];
            e_abort = !req_valid[owner] && (stall == TIMEOUT - 1);
        end
        check_eq("busy", 32'(busy), 32'(owner >= 0));
        check_eq("req_ready", 32'(req_ready), 32'(e_ready));
        check_eq("fifo_wen", 32'(fifo_wen), 32'(e_wen));
        check_eq("abort", 32'(abort), 32'(e_abort));
        if (owner >= 0) check_eq("grant_id", 32'(grant_id), 32'(owner));
        if (e_wen) check_eq("fifo_wdata", 32'(fifo_wdata), 32'(pdata[owner]));
        if (fifo_wen) dut_wen_cnt++;

        rd = (fifo_cnt > 0) && ($urandom_range(99) < rprob);
        if (owner < 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int j;
                j = (rr + k) % NUM_REQ;
                if (owner < 0 && req_valid[j]) owner = j;
            end
`ifdef FIFO_WR_ARB_PRIO0_EN
            if (req_valid[0]) owner = 0;
`endif
            beats = 0;
            stall = 0;
        end else if (!fifo_full) begin
            if (req_valid[owner]) begin
                was_last = req_last[owner];
                bidx[owner]++;
                if (bidx[owner] == blen[owner]) begin
                    bidx[owner] = 0;
                    blen[owner] = $urandom_range(7, 1);
                end
                pdata[owner] = 8'($urandom);
                beats++;
                stall = 0;
                if (was_last || beats == BURST_MAX) release_owner();
            end else begin
                stall++;
                if (stall == TIMEOUT) release_owner();
            end
        end
        fifo_cnt = fifo_cnt + int'(e_wen) - int'(rd);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hold[i] == 0 && $urandom_range(99) < hprob) hold[i] = $urandom_range(12, 1);
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    // Reset lands between edges while a beat is on the port.
    task automatic mid_reset();
        #2;
        check_eq("pre_rst_wen", 32'(fifo_wen), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_wen", 32'(fifo_wen), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_abort", 32'(abort), 32'd0);
        check_eq("rst_grant", 32'(grant_id), 32'd0);
        owner = -1;
        rr = 0;
        beats = 0;
        stall = 0;
        rst_done = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) hold[i] = 0;
        drive();
        req_valid = '1;
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            blen[i]  = 2;
            bidx[i]  = 0;
            hold[i]  = 0;
            pdata[i] = 8'($urandom);
        end
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_grant", 32'(grant_id), 32'd0);
        check_eq("reset_ready", 32'(req_ready), 32'd0);
        check_eq("reset_wen", 32'(fifo_wen), 32'd0);
        check_eq("reset_abort", 32'(abort), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive();

        for (int c = 0; c < 4000; c++) begin
            if (c >= 12) begin
                case ((c / 400) % 3)
                    0: begin vprob = 85;  hprob = 3;  rprob = 60; end
                    1: begin vprob = 95;  hprob = 1;  rprob = 10; end
                    default: begin vprob = 70; hprob = 15; rprob = 40; end
                endcase
            end
            if (c >= 2000 && !rst_done && owner >= 0 && req_valid[owner] && !fifo_full) begin
                mid_reset();
            end
            cycle();
            if (c == 11) check_eq("first_round_beats", 32'(dut_wen_cnt), 32'd8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
